// File: rtl/sram_port_arbiter_pkg.sv
// Shared helpers for the SRAM port arbiter: index width and the round-robin pick.
package sram_arb_pkg;

   localparam int MAX_REQ   = 32;
   localparam int MAX_IDX_W = 5;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // One-hot winner: first set bit of req scanning ptr, ptr+1, ... mod n.
   function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                  input int ptr, input int n);
      logic [MAX_REQ-1:0] gnt;
      logic               found;
      int                 idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_REQ; i++) begin
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if (i < n && !found && req[idx[MAX_IDX_W-1:0]]) begin
            gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
            found = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-side bus of the arbiter; master = requesters + SRAM, slave = arbiter.
interface sram_port_arbiter_if #(
   parameter int N_REQ    = 2,
   parameter int LEN_ADDR = 32,
   parameter int LEN_DATA = 32
);
   logic [N_REQ-1:0]                     req_valid;
   logic [N_REQ-1:0][LEN_ADDR-1:0]       req_addr;
   logic [N_REQ-1:0][LEN_DATA-1:0]       req_wdata;
   logic [N_REQ-1:0][LEN_DATA/8-1:0]     req_wstrb;
   logic [N_REQ-1:0]                     req_gnt;
   logic [N_REQ-1:0]                     rsp_valid;
   logic [LEN_DATA-1:0]                  rsp_rdata;
   logic [LEN_ADDR-1:0]                  sram_addra;
   logic [LEN_DATA-1:0]                  sram_dina;
   logic [LEN_DATA-1:0]                  sram_douta;
   logic                                 sram_ena;
   logic [LEN_DATA/8-1:0]                sram_wea;

   modport master (
      output req_valid, req_addr, req_wdata, req_wstrb, sram_douta,
      input  req_gnt, rsp_valid, rsp_rdata, sram_addra, sram_dina, sram_ena, sram_wea
   );

   modport slave (
      input  req_valid, req_addr, req_wdata, req_wstrb, sram_douta,
      output req_gnt, rsp_valid, rsp_rdata, sram_addra, sram_dina, sram_ena, sram_wea
   );
endinterface

// File: rtl/sram_port_arbiter_core.sv
// Round-robin grant core: owns rr_ptr, produces the same-cycle one-hot winner and its index.
module rr_arbiter_core
   import sram_arb_pkg::*;
#(
   parameter  int N_REQ = 2,
   localparam int IDX_W = idx_width(N_REQ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0] gnt_idx
);

   logic [IDX_W-1:0]   rr_ptr;
   logic [MAX_REQ-1:0] pick;
   logic               unused_pick;

   assign pick        = rr_pick(MAX_REQ'(req), int'(rr_ptr), N_REQ);
   assign gnt_onehot  = pick[N_REQ-1:0];
   assign unused_pick = ^pick;

   always_comb begin
      gnt_idx = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt_onehot[i]) gnt_idx = IDX_W'(i);
   end

   // Pointer moves just past the winner so it becomes lowest priority next cycle.
   always_ff @(posedge clk) begin
      if (rst)
         rr_ptr <= '0;
      else if (advance)
         rr_ptr <= (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port synchronous SRAM between N_REQ requesters, round-robin, one access per cycle.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int LEN_ADDR = 32,
   parameter int LEN_DATA = 32
) (
   input logic                clk,
   input logic                rst,
   sram_port_arbiter_if.slave bus
);

   localparam int IDX_W  = idx_width(N_REQ);
   localparam int STAGES = 1;

   logic [N_REQ-1:0] gnt_raw;
   logic [N_REQ-1:0] req_rd;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] rd_owner;
   logic [STAGES:0]  vld_pipe;
   logic             any_req;
   logic             advance;

   assign any_req = |bus.req_valid;
   assign advance = any_req & ~rst;

   rr_arbiter_core #(.N_REQ(N_REQ)) u_core (
      .clk        (clk),
      .rst        (rst),
      .req        (bus.req_valid),
      .advance    (advance),
      .gnt_onehot (gnt_raw),
      .gnt_idx    (win_idx)
   );

   for (genvar k = 0; k < N_REQ; k++) begin : g_lane
      assign req_rd[k] = ~|bus.req_wstrb[k];
   end

   // Reset forces the SRAM and grants quiet combinationally.
   assign bus.req_gnt    = rst ? '0 : gnt_raw;
   assign bus.sram_ena   = advance;
   assign bus.sram_addra = any_req ? bus.req_addr[win_idx]  : '0;
   assign bus.sram_dina  = any_req ? bus.req_wdata[win_idx] : '0;
   assign bus.sram_wea   = advance ? bus.req_wstrb[win_idx] : '0;

   assign vld_pipe[0] = |(bus.req_gnt & req_rd);

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe[STAGES] <= 1'b0;
         rd_owner         <= '0;
      end else begin
         vld_pipe[STAGES] <= vld_pipe[0];
         if (vld_pipe[0]) rd_owner <= win_idx;
      end
   end

   // SRAM data lands one cycle after the read grant; only the owner flag is registered.
   assign bus.rsp_valid = vld_pipe[STAGES] ? (N_REQ'(1) << rd_owner) : '0;
   assign bus.rsp_rdata = bus.sram_douta;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed + random checks of sram_port_arbiter against a queue/array reference model.
module tb_sram_port_arbiter;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   logic clk = 1'b0;
   logic rst;
   logic preload;

   always #5 clk = ~clk;

   sram_port_arbiter_if #(.N_REQ(N), .LEN_ADDR(AW), .LEN_DATA(DW)) bus ();

   sram_port_arbiter #(.N_REQ(N), .LEN_ADDR(AW), .LEN_DATA(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [DW-1:0] init_word(input int i);
      return (i == 16) ? 32'hDEADBEEF : 32'hAAAAAAAA;
   endfunction

   // Behavioural SRAM: one-cycle read latency, byte write enables.
   logic [DW-1:0] sram_mem [256];
   always @(posedge clk) begin : sram_model
      logic [DW-1:0] w;
      if (preload) begin
         for (int i = 0; i < 256; i++) sram_mem[i] <= init_word(i);
      end else if (bus.sram_ena) begin
         if (|bus.sram_wea) begin
            w = sram_mem[bus.sram_addra[7:0]];
            for (int b = 0; b < SW; b++)
               if (bus.sram_wea[b]) w[b*8 +: 8] = bus.sram_dina[b*8 +: 8];
            sram_mem[bus.sram_addra[7:0]] <= w;
         end else begin
            bus.sram_douta <= sram_mem[bus.sram_addra[7:0]];
         end
      end
   end

   // Reference model state
   int            ptr;
   logic [N-1:0]  pend_rsp;
   logic [DW-1:0] pend_data;
   logic [DW-1:0] ref_mem [256];
   int            last_win;
   logic [N-1:0]  obs_gnt, obs_rsp;
   logic [DW-1:0] obs_rdata;
   int            gcount [N];
   int            checks, errors;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s);
      bus.req_valid[k] = 1'b1;
      bus.req_addr[k]  = a;
      bus.req_wdata[k] = d;
      bus.req_wstrb[k] = s;
   endtask

   // One clock: check combinational/registered outputs mid-cycle, then advance the model.
   task automatic step();
      int           win;
      int           k;
      logic [N-1:0] one;
      logic [N-1:0] exp_gnt;
      logic [AW-1:0] a;
      one = 1;
      @(negedge clk);
      win = -1;
      if (!rst)
         for (int i = 0; i < N; i++) begin
            k = (ptr + i) % N;
            if (win < 0 && bus.req_valid[k]) win = k;
         end
      exp_gnt   = (win >= 0) ? (one << win) : '0;
      obs_gnt   = bus.req_gnt;
      obs_rsp   = bus.rsp_valid;
      obs_rdata = bus.rsp_rdata;
      check("gnt", 64'(obs_gnt), 64'(exp_gnt));
      check("ena", 64'(bus.sram_ena), 64'(!rst && (bus.req_valid != '0)));
      check("wea", 64'(bus.sram_wea), (win >= 0) ? 64'(bus.req_wstrb[win]) : 64'(0));
      if (!rst) begin
         check("addra", 64'(bus.sram_addra), (win >= 0) ? 64'(bus.req_addr[win])  : 64'(0));
         check("dina",  64'(bus.sram_dina),  (win >= 0) ? 64'(bus.req_wdata[win]) : 64'(0));
      end
      check("rsp_valid", 64'(obs_rsp), 64'(pend_rsp));
      if (pend_rsp != '0) check("rdata", 64'(obs_rdata), 64'(pend_data));
      for (int j = 0; j < N; j++) gcount[j] += int'(obs_gnt[j]);
      @(posedge clk);
      if (rst) begin
         ptr      = 0;
         pend_rsp = '0;
      end else begin
         pend_rsp = '0;
         if (win >= 0) begin
            ptr = (win + 1) % N;
            a   = bus.req_addr[win];
            if (bus.req_wstrb[win] == '0) begin
               pend_rsp  = one << win;
               pend_data = ref_mem[a[7:0]];
            end else begin
               for (int b = 0; b < SW; b++)
                  if (bus.req_wstrb[win][b]) ref_mem[a[7:0]][b*8 +: 8] = bus.req_wdata[win][b*8 +: 8];
            end
         end
      end
      last_win = win;
      #1;
   endtask

   task automatic drop_granted();
      if (last_win >= 0) bus.req_valid[last_win] = 1'b0;
   endtask

   initial begin
      checks = 0; errors = 0; ptr = 0; pend_rsp = '0; pend_data = '0; last_win = -1;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      for (int j = 0; j < N; j++) gcount[j] = 0;
      bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
      rst = 1'b1; preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;

      // Reset state
      step();
      rst = 1'b0;

      // 1: single read of preloaded word
      set_req(0, 32'h10, '0, '0);
      step(); drop_granted();
      check("t1_gnt", 64'(obs_gnt), 64'(3'b001));
      step();
      check("t1_rsp", 64'(obs_rsp), 64'(3'b001));
      check("t1_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));

      // 2: two readers held continuously for 8 cycles
      for (int j = 0; j < N; j++) gcount[j] = 0;
      for (int c = 0; c < 8; c++) begin
         if (!bus.req_valid[0]) set_req(0, AW'($urandom_range(15)), '0, '0);
         if (!bus.req_valid[1]) set_req(1, AW'($urandom_range(15)), '0, '0);
         step(); drop_granted();
      end
      check("t2_cnt0", 64'(gcount[0]), 64'(4));
      check("t2_cnt1", 64'(gcount[1]), 64'(4));
      bus.req_valid = '0;
      step();

      // 3: partial write then read of same address
      set_req(1, 32'h20, 32'h12345678, 4'b0011);
      step(); drop_granted();
      check("t3_wr_rsp", 64'(obs_rsp), 64'(0));
      set_req(0, 32'h20, '0, '0);
      step(); drop_granted();
      check("t3_wr_norsp", 64'(obs_rsp), 64'(0));
      step();
      check("t3_rsp", 64'(obs_rsp), 64'(3'b001));
      check("t3_rdata", 64'(obs_rdata), 64'(32'hAAAA5678));

      // 4: pointer past requester 0, only requester 0 asks
      set_req(0, 32'h4, '0, '0);
      step(); drop_granted();
      check("t4_gnt", 64'(obs_gnt), 64'(3'b001));
      set_req(0, 32'h5, '0, '0);
      step(); drop_granted();
      check("t4_gnt2", 64'(obs_gnt), 64'(3'b001));

      // 5: reset arrives with a pending read from requester 1
      set_req(1, 32'h6, '0, '0);
      step(); drop_granted();
      set_req(1, 32'h7, '0, '0);
      rst = 1'b1;
      step();
      check("t5_gnt_rst", 64'(obs_gnt), 64'(0));
      rst = 1'b0;
      set_req(0, 32'h8, '0, '0);
      step(); drop_granted();
      check("t5_rsp_after", 64'(obs_rsp), 64'(0));
      check("t5_gnt_ptr0", 64'(obs_gnt), 64'(3'b001));
      bus.req_valid = '0;
      step();

      // 6: idle cycles leave the pointer alone
      for (int c = 0; c < 5; c++) step();
      for (int k = 0; k < N; k++) set_req(k, AW'(k), '0, '0);
      step(); drop_granted();
      check("t6_gnt", 64'(obs_gnt), 64'(3'b010));
      bus.req_valid = '0;
      step();

      // Random traffic with occasional reset
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < N; k++)
            if (!bus.req_valid[k] && $urandom_range(9) < 6)
               set_req(k, AW'($urandom_range(15)), $urandom,
                       ($urandom_range(1) == 1) ? SW'($urandom_range(15)) : SW'(0));
         rst = ($urandom_range(63) == 0);
         step(); drop_granted();
      end
      rst = 1'b0;
      bus.req_valid = '0;
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
